spi_uart_bridge: RTL and testbench
==================================

# spi_uart_bridge

Buffered SPI-to-UART forwarding engine that sits between the SPI slave receive port and the UART transmitter in the top level. It replaces the single-register echo path with a parametrised FIFO and an egress state machine. The egress machine can send each byte raw or as two ASCII hex characters, and can insert CR/LF after a fixed number of payload bytes. Bytes that arrive while the FIFO is full are dropped and counted, never stalled, because the SPI master cannot be back-pressured.

## Interface
Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥ 2.
- HEX_MODE, 0, 0 = send bytes raw; 1 = send each byte as two uppercase ASCII hex characters, high nibble first.
- LINE_BYTES, 0, number of payload bytes after which CR (0x0D) and LF (0x0A) are inserted; 0 disables insertion.

Ports:
- system_clk  in  1  system clock, 27 MHz.
- reset  in  1  asynchronous, active-high reset.
- spi_data_ready  in  1  level from the SPI slave; held high until acknowledged.
- spi_rx_data  in  8  received SPI byte; valid while spi_data_ready is high.
- spi_read_ack  out  1  one-cycle acknowledge to the SPI slave.
- uart_fifo_ready  in  1  UART transmitter can accept a byte.
- uart_tx_data  out  8  byte presented to the UART.
- start_uart  out  1  one-cycle strobe that loads uart_tx_data into the UART.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: at least one byte has been dropped since reset.
- drop_count  out  8  count of dropped bytes; saturates at 255.

## Operation
- **Ingest.**
  - A one-shot flag `taken` arms when spi_data_ready is low.
  - When spi_data_ready is high and `taken` is clear:
    - spi_read_ack pulses for one cycle.
    - `taken` is set.
    - If the FIFO is not full, spi_rx_data is written to the FIFO.
    - If the FIFO is full, the byte is dropped: overflow is set and drop_count increments (saturating at 255).
  - Full is evaluated on the registered count at the start of the cycle. A push that coincides with a pop while full is still dropped.
- **FIFO.**
  - Circular buffer; pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle while not full leave fifo_level unchanged.
- **Egress FSM** (states IDLE, HI, LO, CR, LF, GAP):
  - IDLE: when fifo_level > 0 and uart_fifo_ready is high, pop one byte.
    - Raw mode: drive the byte, pulse start_uart, go to GAP(next = IDLE).
    - Hex mode: latch the byte, drive ASCII of the high nibble ('0'-'9', 'A'-'F'), pulse start_uart, go to GAP(next = LO).
  - Each popped byte increments `line_cnt` (width $clog2(LINE_BYTES+1)). When LINE_BYTES > 0 and the count reaches LINE_BYTES, the FSM's next payload-complete target becomes CR instead of IDLE.
  - LO: when uart_fifo_ready is high, send ASCII of the low nibble, pulse start_uart, go to GAP(next = IDLE or CR).
  - CR: when uart_fifo_ready is high, send 0x0D, go to GAP(next = LF).
  - LF: when uart_fifo_ready is high, send 0x0A, clear line_cnt, go to GAP(next = IDLE).
  - GAP: one idle cycle after every start_uart, so uart_fifo_ready can update. Then go to the recorded next state.
- Every transmitted character results in exactly one start_uart pulse. uart_tx_data is held stable until the next start.
- **Reset.** Asynchronous; may occur mid-transfer. In-flight characters are abandoned and the FIFO contents are discarded.

## Timing
- Reset values:
  - spi_read_ack = 0, start_uart = 0.
  - uart_tx_data = 0x00, fifo_level = 0, overflow = 0, drop_count = 0.
  - FSM in IDLE, pointers = 0, line_cnt = 0, `taken` = 0.
- Ingest: spi_data_ready is sampled high at edge k. spi_read_ack is high in cycle k..k+1 and the FIFO is written at edge k. fifo_level reflects the write after edge k.
- Egress: with an empty FIFO and uart_fifo_ready held high, start_uart rises after edge k+1 (2-cycle latency from spi_data_ready).
- Minimum spacing between start_uart pulses is 2 cycles.
- A spi_data_ready that stays high for many cycles produces exactly one ack and one push.

## Test plan
- Raw mode, DEPTH=16: push 0x41, 0x42, 0x43 with uart_fifo_ready high -> UART receives 0x41, 0x42, 0x43 in order; one ack per byte; fifo_level returns to 0; overflow = 0.
- Hex mode: push 0x3A -> UART receives 0x33 then 0x41. Push 0x0F -> UART receives 0x30 then 0x46.
- LINE_BYTES=4, raw mode: push 8 bytes -> UART stream is b0 b1 b2 b3 0x0D 0x0A b4 b5 b6 b7 0x0D 0x0A.
- Overflow, DEPTH=4: hold uart_fifo_ready low and push 6 bytes -> 6 acks; fifo_level = 4; overflow = 1; drop_count = 2. Release uart_fifo_ready -> the first 4 bytes are sent.
- Push 300 bytes into a full FIFO -> drop_count saturates at 255; overflow stays set.
- Assert reset during the hex LO state with 3 bytes queued -> all outputs return to reset values immediately; no further start_uart pulses; a subsequent push of 0x55 sends 0x35 0x35.

Source files
------------

// File: rtl/spi_uart_bridge.sv
// Buffered SPI-to-UART forwarder: SPI bytes land in a circular FIFO and an egress
// FSM sends them raw or as ASCII hex, optionally breaking lines with CR/LF.
module spi_uart_bridge #(
  parameter int FIFO_DEPTH = 16,
  parameter int HEX_MODE   = 0,
  parameter int LINE_BYTES = 0
) (
  input  logic                          system_clk,
  input  logic                          reset,
  input  logic                          spi_data_ready,
  input  logic [7:0]                    spi_rx_data,
  output logic                          spi_read_ack,
  input  logic                          uart_fifo_ready,
  output logic [7:0]                    uart_tx_data,
  output logic                          start_uart,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (LINE_BYTES > 0) ? $clog2(LINE_BYTES + 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CR, S_LF, S_GAP} state_t;

  state_t        state;
  state_t        nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          taken;
  logic [7:0]    held;
  logic [LW-1:0] line_cnt;
  logic          line_due;
  logic          fire;
  logic          full;
  logic          push;
  logic          pop;
  logic          line_hit;
  logic [7:0]    head;

  // Handshakes: the SPI side is a level (spi_data_ready) consumed once per rising
  // episode and answered with a one-cycle spi_read_ack; it is never stalled. The
  // UART side accepts a character when start_uart pulses, and the FSM only starts
  // one while uart_fifo_ready is high, then idles one cycle so ready can update.
  assign fire       = spi_data_ready && !taken;
  assign full       = (count == (AW + 1)'(FIFO_DEPTH));
  assign push       = fire && !full;
  assign pop        = (state == S_IDLE) && (count != '0) && uart_fifo_ready;
  assign head       = mem[rd_ptr];
  assign line_hit   = (LINE_BYTES > 0) && (line_cnt == LW'(LINE_BYTES - 1));
  assign fifo_level = count;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      taken        <= 1'b0;
      spi_read_ack <= 1'b0;
      overflow     <= 1'b0;
      drop_count   <= 8'h00;
      wr_ptr       <= '0;
    end else begin
      spi_read_ack <= fire;
      if (!spi_data_ready) taken <= 1'b0;
      else if (fire)       taken <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Full is judged on the registered count, so a same-cycle pop cannot save the byte.
      if (fire && full) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge system_clk) begin
    if (push) mem[wr_ptr] <= spi_rx_data;
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      nxt          <= S_IDLE;
      rd_ptr       <= '0;
      line_cnt     <= '0;
      line_due     <= 1'b0;
      held         <= 8'h00;
      uart_tx_data <= 8'h00;
      start_uart   <= 1'b0;
    end else begin
      start_uart <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            line_cnt   <= line_cnt + 1'b1;
            start_uart <= 1'b1;
            state      <= S_GAP;
            if (HEX_MODE != 0) begin
              held         <= head;
              line_due     <= line_hit;
              uart_tx_data <= hex_char(head[7:4]);
              nxt          <= S_LO;
            end else begin
              uart_tx_data <= head;
              nxt          <= line_hit ? S_CR : S_IDLE;
            end
          end
        end
        // IDLE normally sends the high nibble itself; HI resends it from the latch.
        S_HI: begin
          if (uart_fifo_ready) begin
            uart_tx_data <= hex_char(held[7:4]);
            start_uart   <= 1'b1;
            state        <= S_GAP;
            nxt          <= S_LO;
          end
        end
        S_LO: begin
          if (uart_fifo_ready) begin
            uart_tx_data <= hex_char(held[3:0]);
            start_uart   <= 1'b1;
            state        <= S_GAP;
            nxt          <= line_due ? S_CR : S_IDLE;
          end
        end
        S_CR: begin
          if (uart_fifo_ready) begin
            uart_tx_data <= 8'h0D;
            start_uart   <= 1'b1;
            state        <= S_GAP;
            nxt          <= S_LF;
          end
        end
        S_LF: begin
          if (uart_fifo_ready) begin
            uart_tx_data <= 8'h0A;
            start_uart   <= 1'b1;
            line_cnt     <= '0;
            state        <= S_GAP;
            nxt          <= S_IDLE;
          end
        end
        S_GAP:   state <= nxt;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_uart_bridge.sv
// Bench for spi_uart_bridge: four configurations (raw, hex, line-break, shallow FIFO)
// driven from a vector table plus hand-written overflow, saturation and reset sequences.
module tb_spi_uart_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]       spi_rdy;
  logic [3:0][7:0]  spi_dat;
  logic [3:0]       ack;
  logic [3:0]       uready;
  logic [3:0][7:0]  tx;
  logic [3:0]       start;
  logic [3:0]       ovf;
  logic [3:0][7:0]  drops;
  logic [4:0]       lvl_raw, lvl_hex, lvl_line;
  logic [2:0]       lvl_small;

  spi_uart_bridge #(.FIFO_DEPTH(16), .HEX_MODE(0), .LINE_BYTES(0)) u_raw (
    .system_clk(clk), .reset(rst), .spi_data_ready(spi_rdy[0]), .spi_rx_data(spi_dat[0]),
    .spi_read_ack(ack[0]), .uart_fifo_ready(uready[0]), .uart_tx_data(tx[0]),
    .start_uart(start[0]), .fifo_level(lvl_raw), .overflow(ovf[0]), .drop_count(drops[0]));

  spi_uart_bridge #(.FIFO_DEPTH(16), .HEX_MODE(1), .LINE_BYTES(0)) u_hex (
    .system_clk(clk), .reset(rst), .spi_data_ready(spi_rdy[1]), .spi_rx_data(spi_dat[1]),
    .spi_read_ack(ack[1]), .uart_fifo_ready(uready[1]), .uart_tx_data(tx[1]),
    .start_uart(start[1]), .fifo_level(lvl_hex), .overflow(ovf[1]), .drop_count(drops[1]));

  spi_uart_bridge #(.FIFO_DEPTH(16), .HEX_MODE(0), .LINE_BYTES(4)) u_line (
    .system_clk(clk), .reset(rst), .spi_data_ready(spi_rdy[2]), .spi_rx_data(spi_dat[2]),
    .spi_read_ack(ack[2]), .uart_fifo_ready(uready[2]), .uart_tx_data(tx[2]),
    .start_uart(start[2]), .fifo_level(lvl_line), .overflow(ovf[2]), .drop_count(drops[2]));

  spi_uart_bridge #(.FIFO_DEPTH(4), .HEX_MODE(0), .LINE_BYTES(0)) u_small (
    .system_clk(clk), .reset(rst), .spi_data_ready(spi_rdy[3]), .spi_rx_data(spi_dat[3]),
    .spi_read_ack(ack[3]), .uart_fifo_ready(uready[3]), .uart_tx_data(tx[3]),
    .start_uart(start[3]), .fifo_level(lvl_small), .overflow(ovf[3]), .drop_count(drops[3]));

  // Capture side: every start pulse records the character, acks are counted.
  logic [7:0] got0[$], got1[$], got2[$], got3[$];
  int         ack_cnt[4];
  int         spacing_err;
  logic [3:0] start_d;

  initial begin
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    spacing_err = 0;
    start_d     = 4'h0;
  end

  always @(negedge clk) begin
    if (start[0]) got0.push_back(tx[0]);
    if (start[1]) got1.push_back(tx[1]);
    if (start[2]) got2.push_back(tx[2]);
    if (start[3]) got3.push_back(tx[3]);
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) ack_cnt[i]++;
      if (start[i] && start_d[i]) spacing_err++;
    end
    start_d = start;
  end

  function automatic int got_size(input int idx);
    case (idx)
      0: return got0.size();
      1: return got1.size();
      2: return got2.size();
      default: return got3.size();
    endcase
  endfunction

  function automatic logic [7:0] got_at(input int idx, input int pos);
    case (idx)
      0: return got0[pos];
      1: return got1[pos];
      2: return got2[pos];
      default: return got3[pos];
    endcase
  endfunction

  // Scoreboard
  int n_pass;
  int n_total;
  int rd_pos[4];
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Compare the next captured characters of one instance against exp_q, then flush exp_q.
  task automatic drain_check(input int idx, input string nm);
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      if (rd_pos[idx] < got_size(idx)) begin
        check(nm, {24'h0, got_at(idx, rd_pos[idx])}, {24'h0, e});
        rd_pos[idx]++;
      end else begin
        n_total++;
        $display("FAIL %s: got nothing expected 0x%0h", nm, e);
      end
    end
    check({nm, "_extra"}, got_size(idx) - rd_pos[idx], 0);
  endtask

  task automatic push_byte(input int idx, input logic [7:0] b, input int hold);
    spi_dat[idx] = b;
    spi_rdy[idx] = 1'b1;
    repeat (hold) @(negedge clk);
    spi_rdy[idx] = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] din;
    int         nexp;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vt[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    int found;
    n_pass = 0;
    n_total = 0;
    for (int i = 0; i < 4; i++) rd_pos[i] = 0;
    vt[0] = '{0, 8'h41, 1, 8'h41, 8'h00};
    vt[1] = '{0, 8'h42, 1, 8'h42, 8'h00};
    vt[2] = '{0, 8'h43, 1, 8'h43, 8'h00};
    vt[3] = '{1, 8'h3A, 2, 8'h33, 8'h41};
    vt[4] = '{1, 8'h0F, 2, 8'h30, 8'h46};
    vt[5] = '{1, 8'hA5, 2, 8'h41, 8'h35};
    vt[6] = '{1, 8'h90, 2, 8'h39, 8'h30};
    vt[7] = '{0, 8'h00, 1, 8'h00, 8'h00};

    rst     = 1'b1;
    spi_rdy = 4'h0;
    spi_dat = '0;
    uready  = 4'hF;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i), {24'h0, tx[i]}, 32'h0);
      check($sformatf("rst_start%0d", i), {31'h0, start[i]}, 32'h0);
      check($sformatf("rst_ack%0d", i), {31'h0, ack[i]}, 32'h0);
      check($sformatf("rst_ovf%0d", i), {31'h0, ovf[i]}, 32'h0);
      check($sformatf("rst_drops%0d", i), {24'h0, drops[i]}, 32'h0);
    end
    check("rst_lvl_raw", {27'h0, lvl_raw}, 32'h0);
    check("rst_lvl_small", {29'h0, lvl_small}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single-byte vectors, ready held high throughout.
    for (int i = 0; i < 8; i++) begin
      a0 = ack_cnt[vt[i].inst];
      push_byte(vt[i].inst, vt[i].din, 3);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d_acks", i), ack_cnt[vt[i].inst] - a0, 1);
      exp_q.push_back(vt[i].e0);
      if (vt[i].nexp == 2) exp_q.push_back(vt[i].e1);
      drain_check(vt[i].inst, $sformatf("vec%0d_char", i));
    end
    check("raw_level_empty", {27'h0, lvl_raw}, 32'h0);
    check("raw_no_overflow", {31'h0, ovf[0]}, 32'h0);
    check("hex_level_empty", {27'h0, lvl_hex}, 32'h0);

    // Line breaking every 4 payload bytes.
    for (int i = 0; i < 8; i++) push_byte(2, 8'h10 + 8'(i), 2);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      if (i % 4 == 3) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end
    end
    drain_check(2, "line_char");
    check("line_acks", ack_cnt[2], 8);

    // Overflow on the 4-deep FIFO with the UART stalled.
    uready[3] = 1'b0;
    a0 = ack_cnt[3];
    for (int i = 0; i < 6; i++) push_byte(3, 8'h60 + 8'(i), 2);
    repeat (2) @(negedge clk);
    check("ovf_acks", ack_cnt[3] - a0, 6);
    check("ovf_level", {29'h0, lvl_small}, 32'd4);
    check("ovf_flag", {31'h0, ovf[3]}, 32'h1);
    check("ovf_drops", {24'h0, drops[3]}, 32'd2);
    check("ovf_nothing_sent", got_size(3) - rd_pos[3], 0);
    uready[3] = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h60 + 8'(i));
    drain_check(3, "ovf_char");
    check("ovf_level_drained", {29'h0, lvl_small}, 32'h0);

    // Drop counter saturation: fill, then 300 pushes into the full FIFO.
    uready[3] = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(3, 8'h70 + 8'(i), 1);
    for (int i = 0; i < 100; i++) push_byte(3, 8'hEE, 1);
    check("sat_drops_102", {24'h0, drops[3]}, 32'd102);
    for (int i = 0; i < 200; i++) push_byte(3, 8'hEE, 1);
    check("sat_drops_255", {24'h0, drops[3]}, 32'd255);
    check("sat_flag", {31'h0, ovf[3]}, 32'h1);
    check("sat_level", {29'h0, lvl_small}, 32'd4);
    uready[3] = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h70 + 8'(i));
    drain_check(3, "sat_char");

    // Reset while the hex FSM waits in LO with bytes queued.
    uready[1] = 1'b0;
    push_byte(1, 8'h11, 2);
    push_byte(1, 8'h22, 2);
    push_byte(1, 8'h33, 2);
    check("rstlo_level", {27'h0, lvl_hex}, 32'd3);
    uready[1] = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (start[1]) found = 1;
    end
    uready[1] = 1'b0;
    check("rstlo_first_start_seen", found, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstlo_tx", {24'h0, tx[1]}, 32'h0);
    check("rstlo_start", {31'h0, start[1]}, 32'h0);
    check("rstlo_level0", {27'h0, lvl_hex}, 32'h0);
    check("rstlo_small_ovf", {31'h0, ovf[3]}, 32'h0);
    check("rstlo_small_drops", {24'h0, drops[3]}, 32'h0);
    exp_q.push_back(8'h31);
    drain_check(1, "rstlo_pre");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    uready[1] = 1'b1;
    repeat (10) @(negedge clk);
    check("rstlo_no_more_starts", got_size(1) - rd_pos[1], 0);
    push_byte(1, 8'h55, 2);
    repeat (10) @(negedge clk);
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h35);
    drain_check(1, "rstlo_post");

    check("start_spacing", spacing_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
